// File: rtl/vga_scan_reader_if.sv
// Frame-buffer read and VGA output bundle for vga_scan_reader.
// The master side is the scan reader; the slave side is the RAM/DAC environment.
interface vga_scan_reader_if #(
    parameter int DATA_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] iReadData;
    logic                  iPatternSel;
    logic [24:0]           oReadAddress;
    logic [DATA_WIDTH-1:0] oRGB;
    logic                  oHSync;
    logic                  oVSync;
    logic                  oPixelTick;
    logic                  oFrameStart;

    modport master (
        input  iReadData,
        input  iPatternSel,
        output oReadAddress,
        output oRGB,
        output oHSync,
        output oVSync,
        output oPixelTick,
        output oFrameStart
    );

    modport slave (
        output iReadData,
        output iPatternSel,
        input  oReadAddress,
        input  oRGB,
        input  oHSync,
        input  oVSync,
        input  oPixelTick,
        input  oFrameStart
    );
endinterface

// File: rtl/vga_scan_reader.sv
// VGA scan-out reader: timing generator, frame-buffer address sequencer and 2-stage pixel pipeline.
// Optional colour-bar generator is enabled with the macro VGA_TEST_PATTERN_EN.
module vga_scan_reader #(
    parameter int DATA_WIDTH = 3,
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic              Clock,
    input  logic              Reset,
    vga_scan_reader_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);
    localparam int AW      = 25;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic          tick;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap;
    logic          v_wrap;
    logic          frame_wrap;
    logic          visible;
    logic          hs_act;
    logic          vs_act;
    logic [AW-1:0] pix_cnt;

    logic          vld_p1;
    logic          hs_act_p1;
    logic          vs_act_p1;
    logic [DATA_WIDTH-1:0] pixel_src;

    // Pixel-rate divider; the tick marks the last system clock of each pixel period.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign tick            = (div == DIV_LAST);
    assign h_wrap          = (h == H_LAST);
    assign v_wrap          = (v == V_LAST);
    assign frame_wrap      = tick && h_wrap && v_wrap;
    assign bus.oPixelTick  = tick;
    assign bus.oFrameStart = frame_wrap;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            h <= h_wrap ? '0 : h + HW'(1);
            if (h_wrap) begin
                v <= v_wrap ? '0 : v + VW'(1);
            end
        end
    end

    assign visible = (h < H_VIS) && (v < V_VIS);
    assign hs_act  = (h >= HS_START) && (h < HS_END);
    assign vs_act  = (v >= VS_START) && (v < VS_END);

    // Stage 1: address issue. Visible pixels arrive in raster order, so a running
    // count equals V*H_VISIBLE+H without a multiplier. Syncs are held active-high here.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pix_cnt          <= '0;
            bus.oReadAddress <= '0;
            vld_p1           <= 1'b0;
            hs_act_p1        <= 1'b0;
            vs_act_p1        <= 1'b0;
        end else if (tick) begin
            if (visible) begin
                bus.oReadAddress <= pix_cnt;
                pix_cnt          <= pix_cnt + AW'(1);
            end else begin
                bus.oReadAddress <= '0;
            end
            if (frame_wrap) begin
                pix_cnt <= '0;
            end
            vld_p1    <= visible;
            hs_act_p1 <= hs_act;
            vs_act_p1 <= vs_act;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;
    localparam int BW    = $clog2(BAR_W);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_p1;

    // Bar index tracks H/BAR_W incrementally alongside the H counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bar_px  <= '0;
            bar_idx <= '0;
            bar_p1  <= '0;
        end else if (tick) begin
            bar_p1 <= bar_idx;
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + BW'(1);
            end
        end
    end

    assign pixel_src = bus.iPatternSel ? DATA_WIDTH'(bar_p1) : bus.iReadData;
`else
    logic sel_unused;

    assign sel_unused = bus.iPatternSel;
    assign pixel_src  = bus.iReadData;
`endif

    // Stage 2: capture RAM data (settled since the stage-1 update) and align syncs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.oRGB   <= '0;
            bus.oHSync <= 1'b1;
            bus.oVSync <= 1'b1;
        end else if (tick) begin
            bus.oRGB   <= vld_p1 ? pixel_src : '0;
            bus.oHSync <= !hs_act_p1;
            bus.oVSync <= !vs_act_p1;
        end
    end
endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench for vga_scan_reader: full horizontal timing, shortened vertical
// timing (8 lines per frame) so whole frames fit in a short run.
module tb_vga_scan_reader;
    localparam int DATA_WIDTH = 3;
    localparam int CLK_DIV    = 2;
    localparam int V_VISIBLE  = 4;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 1;
    localparam int FRAME_TICKS = 800 * (V_VISIBLE + V_FP + V_SYNC + V_BP);

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [2:0] E5 = 3'd0, E79 = 3'd0, E80 = 3'd1, E85 = 3'd1, E603 = 3'd7, E639 = 3'd7;
`else
    localparam logic [2:0] E5 = 3'd5, E79 = 3'd7, E80 = 3'd0, E85 = 3'd5, E603 = 3'd3, E639 = 3'd7;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] ram_bias = 3'd0;

    int checks = 0;
    int errors = 0;
    int cyc, ticks, hs_low, vs_low, fs_n, fs_cyc;

    always #5 Clock = ~Clock;

    vga_scan_reader_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    vga_scan_reader #(
        .DATA_WIDTH(DATA_WIDTH),
        .CLK_DIV   (CLK_DIV),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // Frame-buffer model: 1-cycle registered read, data = address[2:0] (optionally biased).
    always @(posedge Clock) begin
        bus.iReadData <= bus.oReadAddress[2:0] ^ ram_bias;
    end

    // Event monitor sampling pre-edge values at each clock.
    always @(posedge Clock) begin
        if (Reset) begin
            cyc <= 0; ticks <= 0; hs_low <= 0; vs_low <= 0; fs_n <= 0; fs_cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (bus.oPixelTick) begin
                ticks <= ticks + 1;
                if (!bus.oHSync) hs_low <= hs_low + 1;
                if (!bus.oVSync) vs_low <= vs_low + 1;
            end
            if (bus.oFrameStart) begin
                fs_n   <= fs_n + 1;
                fs_cyc <= cyc + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance until the given number of tick edges since reset; sample 1 time unit after.
    task automatic go_to(input int target);
        int n = 0;
        while (ticks != target && n < 40000) begin
            @(posedge Clock);
            #1;
            n++;
        end
        if (ticks != target) check_eq("tick_timeout", ticks, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, 32'(bus.oReadAddress), 0);
        check_eq({tag, "_rgb"},  32'(bus.oRGB), 0);
        check_eq({tag, "_hs"},   32'(bus.oHSync), 1);
        check_eq({tag, "_vs"},   32'(bus.oVSync), 1);
        check_eq({tag, "_tick"}, 32'(bus.oPixelTick), 0);
        check_eq({tag, "_fs"},   32'(bus.oFrameStart), 0);
    endtask

    // After tick edge k, oRGB/syncs show pixel k-2 and oReadAddress holds pixel k-1.
    initial begin
        bus.iPatternSel = 1'b0;
        Reset = 1'b1;
        repeat (5) @(posedge Clock);
        #1;
        check_reset_outputs("rst");

        @(negedge Clock);
        Reset = 1'b0;
        check_eq("tick_at_release", 32'(bus.oPixelTick), 0);
        @(posedge Clock); #1;
        check_eq("tick_first", 32'(bus.oPixelTick), 1);
        @(posedge Clock); #1;
        check_eq("tick_after_first", 32'(bus.oPixelTick), 0);
        check_eq("tick_count_1", ticks, 1);

        go_to(7);
        check_eq("rgb_x5_y0", 32'(bus.oRGB), 5);
        check_eq("addr_x6_y0", 32'(bus.oReadAddress), 6);
        check_eq("hs_x5", 32'(bus.oHSync), 1);
        go_to(644);
        check_eq("rgb_hblank", 32'(bus.oRGB), 0);
        check_eq("addr_hblank", 32'(bus.oReadAddress), 0);
        go_to(657);
        check_eq("hs_x655", 32'(bus.oHSync), 1);
        go_to(658);
        check_eq("hs_x656", 32'(bus.oHSync), 0);
        go_to(753);
        check_eq("hs_x751", 32'(bus.oHSync), 0);
        go_to(754);
        check_eq("hs_x752", 32'(bus.oHSync), 1);
        go_to(804);
        check_eq("rgb_x2_y1", 32'(bus.oRGB), 2);
        check_eq("addr_x3_y1", 32'(bus.oReadAddress), 643);

        go_to(1500);
        ram_bias = 3'd6;
        go_to(1502);
        check_eq("rgb_blank_nonzero_data", 32'(bus.oRGB), 0);
        check_eq("hs_x700_y1", 32'(bus.oHSync), 0);
        go_to(1603);
        check_eq("rgb_x1_y2_biased", 32'(bus.oRGB), 7);
        ram_bias = 3'd0;

        go_to(3040);
        check_eq("addr_last_visible", 32'(bus.oReadAddress), 2559);
        go_to(3041);
        check_eq("rgb_last_visible", 32'(bus.oRGB), 7);
        go_to(3211);
        check_eq("addr_vblank", 32'(bus.oReadAddress), 0);
        check_eq("vs_y4", 32'(bus.oVSync), 1);
        go_to(4001);
        check_eq("vs_y4_end", 32'(bus.oVSync), 1);
        go_to(4002);
        check_eq("vs_y5_start", 32'(bus.oVSync), 0);
        go_to(5601);
        check_eq("vs_y6_end", 32'(bus.oVSync), 0);
        go_to(5602);
        check_eq("vs_y7_start", 32'(bus.oVSync), 1);

        go_to(FRAME_TICKS);
        check_eq("hs_low_ticks_frame", hs_low, 768);
        check_eq("vs_low_ticks_frame", vs_low, 1600);
        check_eq("frame_start_count", fs_n, 1);
        check_eq("frame_start_cycle", fs_cyc, FRAME_TICKS * CLK_DIV);
        check_eq("frame_start_low", 32'(bus.oFrameStart), 0);
        go_to(FRAME_TICKS + 5);
        check_eq("addr_frame1_x4", 32'(bus.oReadAddress), 4);
        check_eq("rgb_frame1_x3", 32'(bus.oRGB), 3);

        bus.iPatternSel = 1'b1;
        go_to(FRAME_TICKS + 7);
        check_eq("sel_x5", 32'(bus.oRGB), 32'(E5));
        go_to(FRAME_TICKS + 81);
        check_eq("sel_x79", 32'(bus.oRGB), 32'(E79));
        go_to(FRAME_TICKS + 82);
        check_eq("sel_x80", 32'(bus.oRGB), 32'(E80));
        go_to(FRAME_TICKS + 87);
        check_eq("sel_x85", 32'(bus.oRGB), 32'(E85));
        go_to(FRAME_TICKS + 605);
        check_eq("sel_x603", 32'(bus.oRGB), 32'(E603));
        go_to(FRAME_TICKS + 641);
        check_eq("sel_x639", 32'(bus.oRGB), 32'(E639));
        check_eq("sel_addr_runs", 32'(bus.oReadAddress), 0);
        go_to(FRAME_TICKS + 732);
        check_eq("sel_x730_blank", 32'(bus.oRGB), 0);
        check_eq("sel_x730_hs", 32'(bus.oHSync), 0);
        bus.iPatternSel = 1'b0;

        // Pulse reset with counters at H=300, V=2 of frame 1.
        go_to(FRAME_TICKS + 2 * 800 + 300);
        Reset = 1'b1;
        @(posedge Clock); #1;
        check_reset_outputs("midrst");
        Reset = 1'b0;
        go_to(7);
        check_eq("post_rst_rgb_x5", 32'(bus.oRGB), 5);
        check_eq("post_rst_addr_x6", 32'(bus.oReadAddress), 6);
        go_to(FRAME_TICKS);
        check_eq("post_rst_fs_count", fs_n, 1);
        check_eq("post_rst_fs_cycle", fs_cyc, FRAME_TICKS * CLK_DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scan_reader.md
Name: vga_scan_reader

Overview:
- Downstream consumer of the dual-port frame-buffer RAM (640x480, 3-bit RGB, 1-cycle registered read).
- Generates 640x480@60 VGA timing from the board clock and drives the RAM read address.
- Captures the returned pixel and emits RGB and syncs aligned to the same pixel.
- Also exports a frame-start strobe so upstream writers can sync to vertical blank.

Parameters:
- DATA_WIDTH, 3, pixel width; must equal the RAM data width.
- CLK_DIV, 2, Clock cycles per pixel; legal range 2..16; 50 MHz / 2 = 25 MHz pixel rate.
- H_VISIBLE, H_FP, H_SYNC, H_BP: 640, 16, 96, 48 pixels; H_TOTAL = 800.
- V_VISIBLE, V_FP, V_SYNC, V_BP: 480, 10, 2, 33 lines; V_TOTAL = 525.

Ports:
- Clock  input  1  system clock, same clock as the frame-buffer RAM.
- Reset  input  1  synchronous, active-high reset.
- iReadData  input  DATA_WIDTH  RAM read data, valid 1 Clock after address.
- iPatternSel  input  1  selects test pattern. Ignored unless the macro is defined.
- oReadAddress  output  25  RAM read address.
- oRGB  output  DATA_WIDTH  pixel to DAC; bit2=R, bit1=G, bit0=B.
- oHSync  output  1  horizontal sync, active low.
- oVSync  output  1  vertical sync, active low.
- oPixelTick  output  1  one-Clock pulse per pixel period.
- oFrameStart  output  1  one-Clock pulse when the counters wrap to (0,0).

Behaviour:
- Reset values: oReadAddress=0, oRGB=0, oHSync=1, oVSync=1, oPixelTick=0, oFrameStart=0. Divider, H and V counters and all pipeline registers are 0.
- Pixel tick:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - Tick is asserted in the Clock cycle where divider = CLK_DIV-1; oPixelTick mirrors it.
  - First tick after reset release occurs CLK_DIV cycles later.
- Counters (update on tick only):
  - H counts 0..799 and wraps to 0.
  - V increments when H wraps, counts 0..524, and wraps to 0.
- Stage 1 (on tick, from pre-increment counters H,V):
  - visible = H<640 && V<480.
  - hs = !(656<=H<752); vs = !(490<=V<492).
  - oReadAddress <= visible ? V*640+H : 0.
  - visible, hs and vs are registered alongside the address.
- RAM latency: iReadData is stable from 1 Clock after the address update until the next tick, because CLK_DIV>=2.
- Stage 2 (on tick):
  - oRGB <= stage1 visible ? iReadData : 0.
  - oHSync and oVSync load the stage-1 hs and vs values.
- Alignment:
  - oRGB, oHSync and oVSync all lag the counters by exactly 2 ticks and stay mutually aligned.
  - Outputs change only on tick edges.
- Blanking: oRGB is exactly 0 whenever the aligned pixel is outside the visible region.
- Address arithmetic:
  - Implement as a running increment: +1 per visible pixel, reset to 0 at frame start.
  - No multiplier. Maximum value is 307199, which fits in 25 bits.
- oFrameStart: asserted for the single Clock cycle of the tick on which H=799 and V=524, i.e. the counters wrap to (0,0).
- Reset mid-frame: all state returns to reset values on the next Clock edge. Timing restarts at (0,0) with no partial-line output.
- No input handshake: the RAM is always readable and the block never stalls.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: when iPatternSel=1, stage 2 replaces iReadData with color bars, pattern = (aligned H / 80) mod 8. This gives 8 bars of 80 pixels: 000, 001, ... 111.
  - Blanking and sync are unchanged.
  - oReadAddress still runs normally.
- Not defined: iPatternSel is unconnected internally, and oRGB always comes from iReadData.

Test Plan:
- Reset held 5 cycles, then released -> reset values hold during reset; first oPixelTick 2 Clocks after release; oHSync=1, oVSync=1.
- Free-run one line -> oHSync low for exactly 96 ticks; falling edge 656 ticks after line start; period 800 ticks = 1600 Clocks.
- Free-run one frame -> oVSync low for exactly 2 lines (1600 ticks); frame period 525*800*2 = 840000 Clocks; oFrameStart pulses once per frame, 1 Clock wide.
- RAM model returns data = address[2:0] -> pixel (x=5, y=0) outputs oRGB=101; (x=639, y=479) has address 307199, oRGB=111. Blanking pixels output 000; address during blanking = 0.
- Assert Reset at (H=300, V=200) for 1 cycle -> next cycle all outputs at reset values; counters restart at 0; next oFrameStart after 840000 Clocks.
- With VGA_TEST_PATTERN_EN and iPatternSel=1 -> visible pixels x=0..79 give 000, x=80..159 give 001, x=560..639 give 111; syncs unchanged.
